// File: rtl/serial_frame_tx_if.sv
// Parallel-byte handshake and serial-line signals of serial_frame_tx.
// master = upstream byte producer, slave = the serializer.
interface serial_frame_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       dir;
  logic       ser_out;
  logic       busy;
  logic       done;

  modport master (
    output data_in, data_valid, dir,
    input  data_ready, ser_out, busy, done
  );

  modport slave (
    input  data_in, data_valid, dir,
    output data_ready, ser_out, busy, done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Framed serializer: start bit, 8 data bits (LSB- or MSB-first), optional
// even parity, stop bit; each bit held CLKS_PER_BIT clocks.
module serial_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input logic         clk,
  input logic         rst,
  serial_frame_tx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       dir_q, dir_d;
  logic       par_q, par_d;
  logic       ser_q, ser_d;
  logic       done_q, done_d;
  logic       last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      par_q   <= 1'b0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      par_q   <= par_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    dir_d   = dir_q;
    par_d   = par_q;
    done_d  = 1'b0;
    ser_d   = 1'b1;
    last    = (cnt_q == LAST);

    if (state_q != IDLE) cnt_d = last ? '0 : cnt_q + 8'd1;

    case (state_q)
      IDLE: if (bus.data_valid) begin
        data_d  = bus.data_in;
        dir_d   = bus.dir;
        par_d   = ^bus.data_in;
        cnt_d   = '0;
        state_d = START;
      end
      START: if (last) begin
        idx_d   = '0;
        state_d = DATA;
      end
      DATA: if (last) begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (last) state_d = STOP;
      STOP: if (last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // ser_out is registered, so it is derived from the upcoming state/index.
    case (state_d)
      START:   ser_d = 1'b0;
      DATA:    ser_d = dir_d ? data_d[idx_d] : data_d[3'd7 - idx_d];
      PARITY:  ser_d = par_d;
      default: ser_d = 1'b1;
    endcase
  end

  assign bus.data_ready = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.ser_out    = ser_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (4 clk/bit with parity, 1 clk/bit
// without) checked against a bit-list frame model.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_frame_tx_if ia ();
  serial_frame_tx_if ib ();

  serial_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  serial_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  int checks = 0;
  int errors = 0;

  localparam int FA = 44;  // (10+1)*4
  localparam int FB = 10;  // (10+0)*1

  // Reference: list of frame bits, each repeated cpb times.
  function automatic logic [0:63] model_wave(input logic [7:0] b, input logic d,
                                             input int cpb, input bit pe);
    logic [0:63] w;
    bit bits[$];
    int pos;
    w = '0;
    pos = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      bits.push_back(d ? ((b >> i) & 8'd1) != 0 : ((b >> (7 - i)) & 8'd1) != 0);
    if (pe) bits.push_back(($countones(b) % 2) == 1);
    bits.push_back(1'b1);
    foreach (bits[j])
      for (int r = 0; r < cpb; r++) begin
        w[pos] = bits[j];
        pos++;
      end
    return w;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] b, input logic d);
    if (sel) begin ib.data_valid = v; ib.data_in = b; ib.dir = d; end
    else     begin ia.data_valid = v; ia.data_in = b; ia.dir = d; end
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic d);
    @(posedge clk); #1 drive(sel, 1'b1, b, d);
    @(posedge clk); #1 drive(sel, 1'b0, b, d);
  endtask

  task automatic capture(input bit sel, input int n, output logic [0:63] s,
                         output logic [0:63] dn, output logic [0:63] rd);
    s = '0; dn = '0; rd = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sel) begin s[k] = ib.ser_out; dn[k] = ib.done; rd[k] = ib.data_ready; end
      else     begin s[k] = ia.ser_out; dn[k] = ia.done; rd[k] = ia.data_ready; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 1'b1, 8'h5A, 1'b1);
    drive(1, 1'b1, 8'hC3, 1'b0);
    repeat (2) begin
      @(negedge clk);
      checks += 2;
      if ({ia.ser_out, ia.busy, ia.data_ready, ia.done} !== 4'b1010) begin
        errors++; $display("FAIL reset_a got %b want 1010", {ia.ser_out, ia.busy, ia.data_ready, ia.done});
      end
      if ({ib.ser_out, ib.busy, ib.data_ready, ib.done} !== 4'b1010) begin
        errors++; $display("FAIL reset_b got %b want 1010", {ib.ser_out, ib.busy, ib.data_ready, ib.done});
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (4) begin
      @(negedge clk);
      checks += 2;
      if ({ia.ser_out, ia.busy, ia.data_ready, ia.done} !== 4'b1010) begin
        errors++; $display("FAIL post_reset_a got %b want 1010", {ia.ser_out, ia.busy, ia.data_ready, ia.done});
      end
      if ({ib.ser_out, ib.busy, ib.data_ready, ib.done} !== 4'b1010) begin
        errors++; $display("FAIL post_reset_b got %b want 1010", {ib.ser_out, ib.busy, ib.data_ready, ib.done});
      end
    end
  endtask

  task automatic test_lsb_frame;
    logic [0:63] s, dn, rd, ew, ed, er;
    send(0, 8'hA5, 1'b1);
    capture(0, FA + 2, s, dn, rd);
    ew = model_wave(8'hA5, 1'b1, 4, 1'b1);
    ew[FA] = 1'b1; ew[FA+1] = 1'b1;
    ed = '0; ed[FA] = 1'b1;
    er = '0; er[FA] = 1'b1; er[FA+1] = 1'b1;
    checks += 3;
    if (s !== ew)  begin errors++; $display("FAIL lsb_wave got %h want %h", s, ew); end
    if (dn !== ed) begin errors++; $display("FAIL lsb_done got %h want %h", dn, ed); end
    if (rd !== er) begin errors++; $display("FAIL lsb_ready got %h want %h", rd, er); end
  endtask

  task automatic test_msb_frame;
    logic [0:63] s, dn, rd, ew, ed;
    fork
      begin
        send(0, 8'h07, 1'b0);
        capture(0, FA + 1, s, dn, rd);
      end
      begin
        repeat (14) @(posedge clk);
        #2 ia.dir = 1'b1; ia.data_in = 8'hFF;
      end
    join
    ew = model_wave(8'h07, 1'b0, 4, 1'b1);
    ew[FA] = 1'b1;
    ed = '0; ed[FA] = 1'b1;
    checks += 2;
    if (s !== ew)  begin errors++; $display("FAIL msb_wave got %h want %h", s, ew); end
    if (dn !== ed) begin errors++; $display("FAIL msb_done got %h want %h", dn, ed); end
  endtask

  task automatic test_back_to_back;
    logic [0:63] s, dn, rd, ew, ed, w1, w2;
    s = '0; dn = '0; rd = '0;
    @(posedge clk); #1 drive(1, 1'b1, 8'h81, 1'b1);
    @(posedge clk); #1 ib.data_in = 8'h3C;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      s[k] = ib.ser_out; dn[k] = ib.done; rd[k] = ib.data_ready;
      if (k == 10) begin @(posedge clk); #1 ib.data_valid = 1'b0; end
    end
    w1 = model_wave(8'h81, 1'b1, 1, 1'b0);
    w2 = model_wave(8'h3C, 1'b1, 1, 1'b0);
    ew = '0;
    for (int i = 0; i < FB; i++) begin ew[i] = w1[i]; ew[FB+1+i] = w2[i]; end
    ew[10] = 1'b1; ew[21] = 1'b1;
    ed = '0; ed[10] = 1'b1; ed[21] = 1'b1;
    checks += 3;
    if (s !== ew)  begin errors++; $display("FAIL b2b_wave got %h want %h", s, ew); end
    if (dn !== ed) begin errors++; $display("FAIL b2b_done got %h want %h", dn, ed); end
    if (rd !== ed) begin errors++; $display("FAIL b2b_ready got %h want %h", rd, ed); end
  endtask

  task automatic test_reset_mid;
    logic [0:63] s, dn, rd, ew, ed;
    logic [7:0] b;
    b = 8'($urandom);
    send(0, b, 1'b1);
    capture(0, 17, s, dn, rd);
    ew = model_wave(b, 1'b1, 4, 1'b1);
    for (int i = 17; i < 64; i++) ew[i] = 1'b0;
    checks++;
    if (s !== ew) begin errors++; $display("FAIL mid_partial got %h want %h", s, ew); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ia.ser_out, ia.busy, ia.data_ready, ia.done} !== 4'b1010) begin
      errors++; $display("FAIL mid_after_rst got %b want 1010", {ia.ser_out, ia.busy, ia.data_ready, ia.done});
    end
    capture(0, 50, s, dn, rd);
    checks += 2;
    if (dn !== 64'h0) begin errors++; $display("FAIL mid_no_done got %h want 0", dn); end
    if (s !== {{50{1'b1}}, 14'h0}) begin errors++; $display("FAIL mid_idle_line got %h want %h", s, {{50{1'b1}}, 14'h0}); end
    send(0, 8'hFF, 1'b1);
    capture(0, FA + 1, s, dn, rd);
    ew = model_wave(8'hFF, 1'b1, 4, 1'b1);
    ew[FA] = 1'b1;
    ed = '0; ed[FA] = 1'b1;
    checks += 2;
    if (s !== ew)  begin errors++; $display("FAIL mid_ff_wave got %h want %h", s, ew); end
    if (dn !== ed) begin errors++; $display("FAIL mid_ff_done got %h want %h", dn, ed); end
  endtask

  task automatic test_holdoff;
    logic [0:63] s, dn, rd, ew, ed;
    logic [7:0] acc_b [3];
    logic       acc_d [3];
    @(posedge clk); #1 drive(0, 1'b1, 8'($urandom), 1'($urandom));
    acc_b[0] = ia.data_in; acc_d[0] = ia.dir;
    for (int f = 0; f < 3; f++) begin
      s = '0; dn = '0; rd = '0;
      for (int k = 0; k < FA + 1; k++) begin
        @(posedge clk); #1;
        if (f == 2 && k == FA) ia.data_valid = 1'b0;
        else begin ia.data_in = 8'($urandom); ia.dir = 1'($urandom); end
        @(negedge clk);
        s[k] = ia.ser_out; dn[k] = ia.done; rd[k] = ia.data_ready;
        if (k == FA && f < 2) begin acc_b[f+1] = ia.data_in; acc_d[f+1] = ia.dir; end
      end
      ew = model_wave(acc_b[f], acc_d[f], 4, 1'b1);
      ew[FA] = 1'b1;
      ed = '0; ed[FA] = 1'b1;
      checks += 3;
      if (s !== ew)  begin errors++; $display("FAIL hold_wave%0d got %h want %h", f, s, ew); end
      if (dn !== ed) begin errors++; $display("FAIL hold_done%0d got %h want %h", f, dn, ed); end
      if (rd !== ed) begin errors++; $display("FAIL hold_ready%0d got %h want %h", f, rd, ed); end
    end
    @(negedge clk);
    checks++;
    if (ia.busy !== 1'b0) begin errors++; $display("FAIL hold_stop got %b want 0", ia.busy); end
  endtask

  task automatic test_random;
    logic [0:63] s, dn, rd, ew, ed;
    logic [7:0] b;
    logic d;
    bit sel;
    int f;
    for (int i = 0; i < 16; i++) begin
      sel = (i % 2) == 1;
      b = 8'($urandom);
      d = 1'($urandom);
      f = sel ? FB : FA;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(sel, b, d);
      capture(sel, f + 1, s, dn, rd);
      ew = sel ? model_wave(b, d, 1, 1'b0) : model_wave(b, d, 4, 1'b1);
      ew[f] = 1'b1;
      ed = '0; ed[f] = 1'b1;
      checks += 2;
      if (s !== ew)  begin errors++; $display("FAIL rand_wave%0d b=%h d=%b got %h want %h", i, b, d, s, ew); end
      if (dn !== ed) begin errors++; $display("FAIL rand_done%0d got %h want %h", i, dn, ed); end
    end
  endtask

  initial begin
    test_reset;
    test_lsb_frame;
    test_msb_frame;
    test_back_to_back;
    test_reset_mid;
    test_holdoff;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
